// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: hazard inputs from the D/E/M stages and stall/busy results back to the pipeline
interface pipe_stall_ctrl_if #(parameter int CNT_W = 4);
    logic [4:0]       D_rs_addr;
    logic [4:0]       D_rt_addr;
    logic [1:0]       D_rs_tuse;
    logic [1:0]       D_rt_tuse;
    logic             D_is_md;
    logic [4:0]       E_wa;
    logic [1:0]       E_tnew;
    logic [4:0]       M_wa;
    logic [1:0]       M_tnew;
    logic             E_md_start;
    logic             E_md_div;
    logic             pc_en;
    logic             D_en;
    logic             D_clr;
    logic             E_clr;
    logic             md_busy;
    logic [CNT_W-1:0] md_cnt;
    logic             md_overlap;
    logic [31:0]      stall_cycles;

    modport master (
        output D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_is_md,
               E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
        input  pc_en, D_en, D_clr, E_clr, md_busy, md_cnt, md_overlap, stall_cycles
    );
    modport slave (
        input  D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_is_md,
               E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
        output pc_en, D_en, D_clr, E_clr, md_busy, md_cnt, md_overlap, stall_cycles
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: Tuse/Tnew and mult/div-busy stall generation, busy countdown and stall counter
module pipe_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input logic               clk,
    input logic               reset,
    pipe_stall_ctrl_if.slave  bus
);
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             md_overlap_q, md_overlap_d;
    logic [31:0]      stall_cycles_q, stall_cycles_d;
    logic             md_busy, stall_rs, stall_rt, stall_md, stall;

    assign md_busy  = md_cnt_q != '0;
    assign stall_rs = (bus.D_rs_addr != 5'd0) && (bus.D_rs_tuse != 2'd3) &&
                      ((bus.E_wa == bus.D_rs_addr && bus.E_tnew > bus.D_rs_tuse) ||
                       (bus.M_wa == bus.D_rs_addr && bus.M_tnew > bus.D_rs_tuse));
    assign stall_rt = (bus.D_rt_addr != 5'd0) && (bus.D_rt_tuse != 2'd3) &&
                      ((bus.E_wa == bus.D_rt_addr && bus.E_tnew > bus.D_rt_tuse) ||
                       (bus.M_wa == bus.D_rt_addr && bus.M_tnew > bus.D_rt_tuse));
    assign stall_md = bus.D_is_md && (md_busy || bus.E_md_start);
    assign stall    = stall_rs || stall_rt || stall_md;

    // reset is asynchronous, so the held-pipeline outputs must follow it without a clock
    assign bus.pc_en        = reset && !stall;
    assign bus.D_en         = reset && !stall;
    assign bus.E_clr        = !reset || stall;
    assign bus.D_clr        = 1'b0;
    assign bus.md_busy      = md_busy;
    assign bus.md_cnt       = md_cnt_q;
    assign bus.md_overlap   = md_overlap_q;
    assign bus.stall_cycles = stall_cycles_q;

    always_comb begin
        md_cnt_d       = (bus.E_md_start && !md_busy) ?
                         (bus.E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)) :
                         md_busy ? md_cnt_q - CNT_W'(1) : '0;
        md_overlap_d   = md_overlap_q || (bus.E_md_start && md_busy);
        stall_cycles_d = (stall && stall_cycles_q != '1) ? stall_cycles_q + 32'd1 : stall_cycles_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_q       <= '0;
            md_overlap_q   <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            md_cnt_q       <= md_cnt_d;
            md_overlap_q   <= md_overlap_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed stimulus, per-cycle compare against a cycle-indexed behavioural model
module tb_pipe_stall_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    pipe_stall_ctrl_if #(.CNT_W(4)) bus();
    pipe_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // model: busy is "cycle index < end cycle of the accepted operation"
    longint cyc = 0;
    longint m_end = 0;
    longint stalls = 0;
    bit     ov = 1'b0;

    function automatic longint exp_cnt();
        return (m_end > cyc) ? m_end - cyc : 0;
    endfunction

    function automatic bit hazard(input logic [4:0] a, input logic [1:0] tuse);
        logic [4:0] wa [2];
        logic [1:0] tn [2];
        wa[0] = bus.E_wa; wa[1] = bus.M_wa;
        tn[0] = bus.E_tnew; tn[1] = bus.M_tnew;
        if (a == 5'd0 || tuse == 2'd3) return 1'b0;
        for (int p = 0; p < 2; p++)
            if (wa[p] == a && int'(tn[p]) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_stall();
        return hazard(bus.D_rs_addr, bus.D_rs_tuse) || hazard(bus.D_rt_addr, bus.D_rt_tuse) ||
               (bus.D_is_md && (exp_cnt() != 0 || bus.E_md_start));
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc = 0; m_end = 0; stalls = 0; ov = 1'b0;
        end else begin
            if (exp_stall() && stalls < 64'hFFFF_FFFF) stalls++;
            if (bus.E_md_start) begin
                if (exp_cnt() == 0) m_end = cyc + 1 + (bus.E_md_div ? 10 : 5);
                else ov = 1'b1;
            end
            cyc++;
        end
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        automatic bit s = exp_stall();
        chk("pc_en", bus.pc_en, reset && !s);
        chk("D_en", bus.D_en, reset && !s);
        chk("E_clr", bus.E_clr, !reset || s);
        chk("D_clr", bus.D_clr, 0);
        chk("md_cnt", bus.md_cnt, exp_cnt());
        chk("md_busy", bus.md_busy, exp_cnt() != 0);
        chk("md_overlap", bus.md_overlap, ov);
        chk("stall_cycles", bus.stall_cycles, stalls);
    end

    task automatic clr_in();
        bus.D_rs_addr = 0; bus.D_rt_addr = 0; bus.D_rs_tuse = 3; bus.D_rt_tuse = 3;
        bus.D_is_md = 0; bus.E_wa = 0; bus.E_tnew = 0; bus.M_wa = 0; bus.M_tnew = 0;
        bus.E_md_start = 0; bus.E_md_div = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        clr_in();
        #12;
        chk("rst pc_en", bus.pc_en, 0);
        chk("rst D_en", bus.D_en, 0);
        chk("rst E_clr", bus.E_clr, 1);
        chk("rst md_cnt", bus.md_cnt, 0);
        reset = 1'b1;
        #1 chk("release pc_en", bus.pc_en, 1);
        tick();
        bus.E_wa = 5; bus.E_tnew = 2; bus.D_rs_addr = 5; bus.D_rs_tuse = 1;
        #1 chk("load-use pc_en", bus.pc_en, 0);
        chk("load-use E_clr", bus.E_clr, 1);
        tick();
        bus.E_wa = 0; bus.M_wa = 5; bus.M_tnew = 1;
        #1 chk("load-use resolved", bus.pc_en, 1);
        tick();
        clr_in();
        bus.E_tnew = 2; bus.D_rs_tuse = 0;
        #1 chk("zero reg", bus.pc_en, 1);
        bus.D_rt_addr = 7; bus.E_wa = 7;
        #1 chk("unused rt", bus.pc_en, 1);
        bus.D_rt_tuse = 2;
        #1 chk("tnew==tuse", bus.pc_en, 1);
        bus.D_rt_tuse = 1;
        #1 chk("tnew>tuse rt", bus.pc_en, 0);
        tick();
        clr_in();
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        bus.D_is_md = 1; bus.E_md_start = 1;
        #1 chk("mult start stall", bus.pc_en, 0);
        tick();
        bus.E_md_start = 0;
        chk("mult cnt", bus.md_cnt, 5);
        for (int i = 4; i >= 0; i--) begin
            tick();
            chk("mult countdown", bus.md_cnt, i);
        end
        chk("mult stalls", bus.stall_cycles, 6);
        chk("mult done pc_en", bus.pc_en, 1);
        bus.D_is_md = 0; bus.E_md_start = 1; bus.E_md_div = 1;
        #1 chk("div start non-md", bus.pc_en, 1);
        tick();
        bus.E_md_start = 0; bus.E_md_div = 0;
        chk("div cnt", bus.md_cnt, 10);
        chk("div busy non-md", bus.pc_en, 1);
        repeat (7) tick();
        chk("div cnt 3", bus.md_cnt, 3);
        bus.E_md_start = 1;
        tick();
        bus.E_md_start = 0;
        chk("overlap cnt", bus.md_cnt, 2);
        chk("overlap flag", bus.md_overlap, 1);
        repeat (2) tick();
        chk("overlap sticky", bus.md_overlap, 1);
        bus.E_md_start = 1;
        tick();
        bus.E_md_start = 0;
        tick();
        chk("cnt 4", bus.md_cnt, 4);
        #1 reset = 1'b0;
        #1 chk("async md_cnt", bus.md_cnt, 0);
        chk("async md_busy", bus.md_busy, 0);
        chk("async stalls", bus.stall_cycles, 0);
        chk("async overlap", bus.md_overlap, 0);
        chk("async pc_en", bus.pc_en, 0);
        tick();
        reset = 1'b1;
        #1 chk("post-reset pc_en", bus.pc_en, 1);
        for (int i = 0; i < 60; i++) begin
            bus.D_rs_addr = 5'(i % 4); bus.D_rs_tuse = 2'(i % 3);
            bus.D_rt_addr = 5'((i / 2) % 4); bus.D_rt_tuse = 2'((i / 3) % 4);
            bus.E_wa = 5'((i / 4) % 4); bus.E_tnew = 2'(i % 3);
            bus.M_wa = 5'((i + 1) % 4); bus.M_tnew = 2'((i / 5) % 3);
            bus.D_is_md = (i % 3 == 0);
            bus.E_md_start = (i % 6 == 1) && exp_cnt() == 0;
            bus.E_md_div = (i % 12 == 1);
            tick();
        end
        clr_in();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
